// File: rtl/weight_pkg.sv
// Shared types and sizes for the weight MAC sequencer and its lanes.
package weight_pkg;
    localparam int NEURONS = 10;
    localparam int WIDTH   = 10;
    localparam int ADDR_W  = 7;
    localparam int IN_W    = 8;
    // Wide enough for 2**ADDR_W worst-case products without wrap.
    localparam int ACC_W   = WIDTH + IN_W + 1 + ADDR_W;

    typedef logic signed [WIDTH-1:0] weight_t;
    typedef weight_t [NEURONS-1:0]   weight_vec_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef acc_t [NEURONS-1:0]      acc_vec_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mac_state_t;
endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane: signed weight times unsigned feature.
// MAC_RELU_EN clamps the presented sum at zero; the stored sum stays signed.
module mac_lane
    import weight_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [WIDTH-1:0]  w,
    input  logic [IN_W-1:0]   x,
    output logic [ACC_W-1:0]  acc
);
    logic signed [WIDTH+IN_W:0] prod;
    acc_t                       sum;

    // Zero-extend the feature so it multiplies as a non-negative signed value.
    assign prod = $signed(w) * $signed({1'b0, x});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     sum <= '0;
        else if (clear) sum <= '0;
        else if (en)    sum <= sum + acc_t'(prod);
    end

`ifdef MAC_RELU_EN
    assign acc = sum[ACC_W-1] ? '0 : sum;
`else
    assign acc = sum;
`endif
endmodule

// File: rtl/weight_mac_sequencer.sv
// Walks WeightRAM addresses 0..DEPTH-1, takes one feature per address and
// accumulates NEURONS signed dot products. Optional MAC_RELU_EN clamps outputs.
module weight_mac_sequencer
    import weight_pkg::*;
#(
    parameter int DEPTH = 100
) (
    input  logic                     Clock,
    input  logic                     Rst,
    input  logic                     Start,
    input  logic                     XValid,
    input  logic [IN_W-1:0]          X,
    output logic                     XReady,
    output logic [ADDR_W-1:0]        Address,
    output logic                     RamOwn,
    input  logic [NEURONS*WIDTH-1:0] Q,
    output logic                     Busy,
    output logic                     Done,
    output logic [NEURONS*ACC_W-1:0] Acc
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    mac_state_t        state;
    logic [ADDR_W-1:0] count;
    logic [IN_W-1:0]   x_q;
    logic              v_q;
    logic              xready;
    logic              busy;
    logic              done;
    logic              clear;
    weight_vec_t       q_vec;
    acc_vec_t          acc_vec;

    // A Start coinciding with the Done pulse is dropped.
    assign clear = (state == IDLE) && Start && !done;

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state  <= IDLE;
            count  <= '0;
            x_q    <= '0;
            v_q    <= 1'b0;
            xready <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            v_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        state  <= RUN;
                        count  <= '0;
                        xready <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (XValid && xready) begin
                        x_q <= X;
                        v_q <= 1'b1;
                        // Address parks on the last entry so Q stays coherent.
                        if (count == LAST) begin
                            state  <= DRAIN;
                            xready <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DRAIN: state <= DONE;
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign q_vec   = Q;
    assign Acc     = acc_vec;
    assign XReady  = xready;
    assign Address = count;
    assign RamOwn  = busy;
    assign Busy    = busy;
    assign Done    = done;

    for (genvar i = 0; i < NEURONS; i++) begin : g_lane
        mac_lane u_lane (
            .clk   (Clock),
            .rst_n (Rst),
            .clear (clear),
            .en    (v_q),
            .w     (q_vec[i]),
            .x     (x_q),
            .acc   (acc_vec[i])
        );
    end
endmodule

// File: doc/weight_mac_sequencer.md
Name: weight_mac_sequencer

Overview:
- Downstream consumer of WeightRAM in the drowsiness-detector datapath.
- On Start, walks RAM addresses 0..DEPTH-1 and accepts one input feature per address over a valid/ready handshake.
- Multiplies each feature by the NEURONS parallel weights read at that address and accumulates one signed dot product per neuron.
- Produces the NEURONS pre-activation sums of one fully connected layer for the next stage.

Parameters:
- NEURONS, 10, parallel weight lanes (matches WeightRAM width).
- WIDTH, 10, weight bits per lane, signed two's complement.
- ADDR_W, 7, RAM address bits.
- DEPTH, 100, inputs per dot product (1..2**ADDR_W).
- IN_W, 8, feature bits, unsigned.
- ACC_W, WIDTH+IN_W+1+ADDR_W (26), accumulator bits, signed.

Ports:
- Clock  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse; begins a pass when idle.
- XValid  in  1  feature X is valid.
- X  in  IN_W  feature value, presented in address order.
- XReady  out  1  block accepts X this cycle.
- Address  out  ADDR_W  read address to WeightRAM.
- RamOwn  out  1  high while Busy; top level muxes Address away from the download path and forces WE=0.
- Q  in  NEURONS x WIDTH  WeightRAM read data, lane i = neuron i.
- Busy  out  1  pass in progress.
- Done  out  1  one-cycle pulse when Acc is final.
- Acc  out  NEURONS x ACC_W  per-neuron sums, held until next Start.

Behaviour:
- Reset (async, Rst=0): state IDLE; Address=0, count=0; XReady=0, Busy=0, RamOwn=0, Done=0; all Acc lanes=0; pipeline valid=0.
- RAM timing: WeightRAM samples Address on the Clock edge; Q is valid the following cycle.
- States:
  - IDLE: Start=1 clears all Acc lanes and count, then goes to RUN. Busy and RamOwn rise the cycle after Start.
  - RUN: XReady=1 and Address=count. A handshake (XValid & XReady) registers X into x_q, sets v_q=1 and increments count. No handshake holds Address and sets v_q=0.
  - RUN exit: the handshake at count==DEPTH-1 moves to DRAIN, and XReady drops the next cycle.
  - DRAIN: one cycle to fold in the last term, then DONE.
  - DONE: Done=1 for one cycle; Busy and RamOwn fall; back to IDLE.
- Accumulate: each cycle with v_q=1, for every lane i, Acc[i] += signed(Q[i]) * signed({1'b0,x_q}). Product is WIDTH+IN_W+1 bits, sign-extended to ACC_W. No overflow is possible within DEPTH<=2**ADDR_W.
- Throughput: one term per cycle while XValid stays high. A pass with XValid always high takes DEPTH+2 cycles from the Start edge to the Done pulse.
- Boundaries:
  - Start while Busy: ignored.
  - Start and Done in the same cycle: Start ignored.
  - XValid outside RUN: ignored, not consumed.
  - count never wraps; Address stays at DEPTH-1 through DRAIN.
  - Reset mid-pass: immediate abort, Acc=0, no Done.
- Acc changes only during RUN/DRAIN and on the clear at Start; it is stable from Done until the next Start.

Optional Feature:
- MAC_RELU_EN defined: the Acc output port presents max(Acc[i],0) per lane. Internal accumulation stays signed; the clamp is combinational on the output.
- Undefined: raw signed sums.

Decomposition:
- Shared package weight_pkg holds:
  - NEURONS, WIDTH, ADDR_W, IN_W and the ACC_W formula;
  - typedefs weight_t (signed WIDTH), weight_vec_t (array of NEURONS weight_t), acc_t, acc_vec_t;
  - state enum mac_state_t {IDLE, RUN, DRAIN, DONE}.
- One sub-module, mac_lane: a single multiply-accumulate lane with clear, enable and optional ReLU output, instantiated NEURONS times.

Test Plan:
- Weights all +1 in every lane, DEPTH=100, X=1..100 with XValid always high:
  - Done 102 cycles after Start; every Acc lane = 5050.
  - XReady high for exactly 100 cycles.
- Lane i weight = i-5 (lane 0 = -5), all X=255:
  - Acc[i] = (i-5)*255*100, e.g. lane 0 = -127500, lane 9 = 102000.
  - With MAC_RELU_EN, lanes 0..4 read 0.
- Bubbles: XValid toggled 1,0,1,0 for 4 inputs with weights 2 and X=10:
  - Address holds during bubbles; Acc=80 in all lanes; Done 2 cycles after the 4th handshake.
- Extremes: weight -512 and X=255 for DEPTH=128:
  - Acc = -16711680 exactly, with no wrap.
- Start pulsed mid-pass at count=40:
  - Ignored; final Acc equals the same pass with no extra Start.
- Rst=0 asserted at count=50:
  - Acc, Busy and RamOwn clear asynchronously; no Done; a fresh Start completes a normal pass.
